// File: rtl/oled_pixel_fetch.sv
// -----------------------------------------------------------------------------
// oled_pixel_fetch
//
// Prefetches frame-buffer pixels ahead of an OLED scan core. Reads are issued
// one at a time to a memory port. Each returned word goes into a small FIFO,
// tagged with its linear address. On each next_pixel pulse the FIFO head is
// compared with the scan position y*C_x_size+x:
//   - On a hit the head word is returned on color.
//   - On a miss C_fallback_color is returned, the FIFO is flushed, and
//     fetching restarts just after the missed address.
//
// Parameters
//   C_x_size         screen width in pixels
//   C_y_size         screen height in pixels
//   C_fifo_depth     prefetch FIFO depth (power of two, 2..16)
//   C_fallback_color color returned on a miss
//
// Ports
//   clk, resetn      single rising-edge clock, asynchronous active-low reset
//   x, y, next_pixel scan position and its one-cycle strobe
//   color            registered RGB565 output, updated the cycle after next_pixel
//   rd_req, rd_addr  read request, held until rd_ack is seen
//   rd_ack, rd_data  one-cycle acknowledge and its data
//   miss_cnt         saturating miss counter
//
// Optional feature: define OLED_PIXEL_FETCH_STATS_EN to build the miss
// counter. Without that macro miss_cnt is tied to zero.
// -----------------------------------------------------------------------------
module oled_pixel_fetch #(
  parameter int          C_x_size         = 128,
  parameter int          C_y_size         = 160,
  parameter int          C_fifo_depth     = 4,
  parameter logic [15:0] C_fallback_color = 16'h0000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [6:0]  x,
  input  logic [7:0]  y,
  input  logic        next_pixel,
  output logic [15:0] color,
  output logic        rd_req,
  output logic [14:0] rd_addr,
  input  logic        rd_ack,
  input  logic [15:0] rd_data,
  output logic [15:0] miss_cnt
);

  localparam int              PW        = $clog2(C_fifo_depth);
  localparam int              CW        = PW + 1;
  localparam logic [14:0]     LAST_ADDR = 15'(C_x_size * C_y_size - 1);
  localparam logic [CW-1:0]   DEPTH     = CW'(C_fifo_depth);

  typedef enum logic {
    S_IDLE,
    S_WAIT
  } state_t;

  state_t        state_q, state_d;
  logic          issue;

  logic [15:0]   fifo_data [C_fifo_depth];
  logic [14:0]   fifo_tag  [C_fifo_depth];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count;

  logic [14:0]   fetch_ptr;
  logic          discard;

  logic [14:0]   target, target_next, issue_addr;
  logic          hit, miss, ack_seen, push, pop;

  // Scan position to linear address. The product is formed at 32 bits, and
  // the result always fits in 15 bits for legal screen sizes.
  assign target      = 15'((32'(y) * 32'(C_x_size)) + 32'(x));
  assign target_next = (target == LAST_ADDR) ? 15'd0 : target + 15'd1;

  // Hit/miss looks at the FIFO as it was before any same-cycle push. A word
  // arriving together with a missing next_pixel is therefore dropped.
  assign hit      = next_pixel && (count != '0) && (fifo_tag[rd_ptr] == target);
  assign miss     = next_pixel && !hit;
  assign ack_seen = rd_ack && (state_q == S_WAIT);
  assign push     = ack_seen && !discard && !miss;
  assign pop      = hit;

  // A request issued in the same cycle as a miss must already point at the
  // restarted stream. Otherwise it would fetch a word that gets thrown away.
  assign issue_addr = miss ? target_next : fetch_ptr;

  assign rd_req = (state_q == S_WAIT);

  // ---------------------------------------------------------------------------
  // Fetch FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
    end else begin
      // NOTE: all clocked state uses non-blocking assignments, so every
      // register samples the pre-edge values regardless of block order.
      state_q <= state_d;
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    state_d = state_q;
    issue   = 1'b0;
    unique case (state_q)
      // Nothing is outstanding in IDLE, so "count + outstanding < depth"
      // reduces to count < depth. A miss empties the FIFO, so a request may
      // be issued in that cycle too.
      S_IDLE: begin
        if (miss || (count < DEPTH)) begin
          state_d = S_WAIT;
          issue   = 1'b1;
        end
      end
      S_WAIT: begin
        if (rd_ack) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Request address, fetch pointer and discard flag
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rd_addr   <= '0;
      fetch_ptr <= '0;
      discard   <= 1'b0;
    end else begin
      if (issue) rd_addr <= issue_addr;

      if (miss)
        fetch_ptr <= target_next;
      else if (push)
        fetch_ptr <= (fetch_ptr == LAST_ADDR) ? 15'd0 : fetch_ptr + 15'd1;

      // The request completing clears the flag. Its word is dropped either
      // by the flag itself or by a miss in the same cycle.
      if (ack_seen)
        discard <= 1'b0;
      else if (miss && (state_q == S_WAIT))
        discard <= 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Prefetch FIFO control
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (miss) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: the storage array has no reset. Its contents are only read
  // through entries that count marks valid, so a reset of the control
  // pointers is enough.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_data[wr_ptr] <= rd_data;
      fifo_tag[wr_ptr]  <= rd_addr;
    end
  end

  // ---------------------------------------------------------------------------
  // Color output: changes only on next_pixel, one cycle of latency
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      color <= '0;
    end else if (next_pixel) begin
      color <= hit ? fifo_data[rd_ptr] : C_fallback_color;
    end
  end

  // ---------------------------------------------------------------------------
  // Miss statistics
  // ---------------------------------------------------------------------------
`ifdef OLED_PIXEL_FETCH_STATS_EN
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      miss_cnt <= '0;
    end else if (miss && (miss_cnt != 16'hFFFF)) begin
      miss_cnt <= miss_cnt + 16'd1;
    end
  end
`else
  assign miss_cnt = '0;
`endif

endmodule

// File: tb/tb_oled_pixel_fetch.sv
// -----------------------------------------------------------------------------
// tb_oled_pixel_fetch
//
// Testbench for oled_pixel_fetch.
//
// The driver plays both roles on the input side:
//   - the memory: it acknowledges each request after a chosen latency and
//     returns data equal to the address;
//   - the scan core: it raises next_pixel for chosen screen positions.
//
// A reference model describes the FIFO contents as a run of consecutive
// addresses. Each restart of the stream opens a new epoch. A request issued
// in an older epoch delivers a word that is not kept. Expected colors go into
// a scoreboard queue, and a monitor pops and compares them.
// -----------------------------------------------------------------------------
module tb_oled_pixel_fetch;

  localparam int          X  = 128;
  localparam int          Y  = 160;
  localparam int          N  = X * Y;
  localparam int          D  = 4;
  localparam logic [15:0] FB = 16'hF81F;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [6:0]  x;
  logic [7:0]  y;
  logic        next_pixel;
  logic [15:0] color;
  logic        rd_req;
  logic [14:0] rd_addr;
  logic        rd_ack;
  logic [15:0] rd_data;
  logic [15:0] miss_cnt;

  oled_pixel_fetch #(
    .C_x_size        (X),
    .C_y_size        (Y),
    .C_fifo_depth    (D),
    .C_fallback_color(FB)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .x         (x),
    .y         (y),
    .next_pixel(next_pixel),
    .color     (color),
    .rd_req    (rd_req),
    .rd_addr   (rd_addr),
    .rd_ack    (rd_ack),
    .rd_data   (rd_data),
    .miss_cnt  (miss_cnt)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Scoreboard of expected colors, one entry per next_pixel.
  logic [15:0] exp_colors[$];

  // Reference model state.
  int mq[$];          // addresses currently held in the prefetch FIFO, head first
  int stream_next = 0;
  int epoch       = 0;
  int miss_exp    = 0;
  int issued[$];      // addresses of requests seen since the last clear

  // Memory-side request tracking.
  bit pend_valid = 1'b0;
  bit just_acked = 1'b0;
  int pend_addr, pend_epoch, pend_wait;
  int lat_min = 2, lat_max = 2;
  bit np_on_ack = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int wrap_inc(input int a);
    return (a == N - 1) ? 0 : a + 1;
  endfunction

  function automatic int exp_miss_cnt();
`ifdef OLED_PIXEL_FETCH_STATS_EN
    return miss_exp;
`else
    return 0;
`endif
  endfunction

  // Runs just after a negedge: checks the outputs produced by the last
  // posedge against the model.
  task automatic observe();
    check("miss_cnt", miss_cnt, exp_miss_cnt());
    if (just_acked) begin
      check("req_after_ack", rd_req, 0);
      just_acked = 1'b0;
    end else if (pend_valid) begin
      check("req_hold", rd_req, 1);
      check("addr_hold", rd_addr, pend_addr);
    end else if (rd_req) begin
      check("req_addr", rd_addr, stream_next);
      check("issue_room", (mq.size() < D), 1);
      pend_valid = 1'b1;
      pend_addr  = int'(rd_addr);
      pend_epoch = epoch;
      pend_wait  = int'($urandom_range(lat_max, lat_min)) - 1;
      issued.push_back(pend_addr);
    end
  endtask

  // One clock cycle: observe, drive the inputs for the next posedge, update
  // the model for that posedge, then move on to the following negedge.
  task automatic cycle(input bit np, input int tgt);
    bit ack;
    bit hit;
    observe();
    ack = 1'b0;
    if (pend_valid) begin
      if (pend_wait == 0) ack = 1'b1;
      else pend_wait--;
    end
    if (np_on_ack && ack && (mq.size() > 0)) begin
      np  = 1'b1;
      tgt = mq[0];
    end
    rd_ack     = ack;
    rd_data    = ack ? 16'(pend_addr) : 16'($urandom);
    next_pixel = np;
    x          = 7'(tgt % X);
    y          = 8'(tgt / X);

    // Hit/miss is decided on the FIFO contents before any arriving word.
    if (np) begin
      hit = (mq.size() > 0) && (mq[0] == tgt);
      if (hit) begin
        exp_colors.push_back(16'(tgt));
        void'(mq.pop_front());
      end else begin
        exp_colors.push_back(FB);
        mq.delete();
        stream_next = wrap_inc(tgt);
        epoch++;
        if (miss_exp < 65535) miss_exp++;
      end
    end
    if (ack) begin
      if (pend_epoch == epoch) begin
        mq.push_back(pend_addr);
        stream_next = wrap_inc(stream_next);
      end
      pend_valid = 1'b0;
      just_acked = 1'b1;
    end
    @(negedge clk);
  endtask

  task automatic fill_wait(input int bound);
    int n = 0;
    while (!((mq.size() == D) && !pend_valid) && (n < bound)) begin
      cycle(1'b0, 0);
      n++;
    end
    if (!((mq.size() == D) && !pend_valid)) begin
      checks++;
      failures++;
      $display("FAIL fill_timeout actual=%0d entries expected=%0d", mq.size(), D);
    end
  endtask

  task automatic expect_issue(input string name, input int idx, input int exp);
    if (issued.size() <= idx) begin
      checks++;
      failures++;
      $display("FAIL %s actual=none expected=%0d", name, exp);
    end else begin
      check(name, issued[idx], exp);
    end
  endtask

  // Monitor: compares color after each next_pixel, and checks that color
  // holds its value in every other cycle.
  initial begin
    logic [15:0] last;
    logic [15:0] e;
    logic        np_s;
    last = 16'h0000;
    forever begin
      @(posedge clk);
      if (!resetn) begin
        last = 16'h0000;
        continue;
      end
      np_s = next_pixel;
      #1;
      if (np_s) begin
        if (exp_colors.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL sb_underflow actual=%0h expected=none", color);
        end else begin
          e = exp_colors.pop_front();
          check("color", color, e);
          last = e;
        end
      end else begin
        check("color_hold", color, last);
      end
    end
  end

  // Driver.
  initial begin
    int n;
    next_pixel = 1'b0;
    rd_ack     = 1'b0;
    rd_data    = '0;
    x          = '0;
    y          = '0;

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_color", color, 0);
    check("rst_req", rd_req, 0);
    check("rst_addr", rd_addr, 0);
    check("rst_miss", miss_cnt, 0);

    // First request must appear at the first edge after release.
    resetn = 1'b1;
    @(negedge clk);
    check("first_req", rd_req, 1);
    check("first_addr", rd_addr, 0);

    // Prime: two-cycle memory, addresses 0..3, then idle with the FIFO full.
    fill_wait(60);
    cycle(1'b0, 0);
    cycle(1'b0, 0);
    check("full_idle", rd_req, 0);
    expect_issue("prime0", 0, 0);
    expect_issue("prime3", 3, 3);

    // Hit on (0,0), then refill starts at address 4.
    issued.delete();
    cycle(1'b1, 0);
    fill_wait(40);
    expect_issue("refill_addr", 0, 4);

    // Miss at (10,2): address 266, stream restarts at 267.
    issued.delete();
    cycle(1'b1, 2 * X + 10);
    fill_wait(60);
    expect_issue("miss_refetch", 0, 267);
`ifdef OLED_PIXEL_FETCH_STATS_EN
    check("miss_one", miss_cnt, 1);
`else
    check("miss_one", miss_cnt, 0);
`endif

    // Wrap: restart at 20479 and hit the bottom-right pixel.
    issued.delete();
    cycle(1'b1, N - 2);
    fill_wait(60);
    expect_issue("wrap_last", 0, N - 1);
    expect_issue("wrap_zero", 1, 0);
    cycle(1'b1, N - 1);
    fill_wait(40);

    // Miss while a request is outstanding; its ack arrives later and is dropped.
    lat_min = 4;
    lat_max = 4;
    cycle(1'b1, mq[0]);
    n = 0;
    while (!pend_valid && (n < 10)) begin
      cycle(1'b0, 0);
      n++;
    end
    cycle(1'b1, 1000);
    fill_wait(80);
    cycle(1'b1, 1001);
    cycle(1'b1, 1002);

    // Ack coincides with a hitting next_pixel while the FIFO holds depth-1.
    lat_min = 2;
    lat_max = 2;
    fill_wait(60);
    cycle(1'b1, mq[0]);
    np_on_ack = 1'b1;
    n = 0;
    while (!just_acked && (n < 10)) begin
      cycle(1'b0, 0);
      n++;
    end
    np_on_ack = 1'b0;
    fill_wait(60);
    for (int i = 0; i < D; i++) cycle(1'b1, mq[0]);

    // Randomized traffic.
    lat_min = 1;
    lat_max = 4;
    for (int i = 0; i < 2500; i++) begin
      int r;
      int t;
      r = int'($urandom_range(99, 0));
      if (r < 25)      t = (mq.size() > 0) ? mq[0] : stream_next;
      else if (r < 35) t = stream_next;
      else             t = int'($urandom_range(N - 1, 0));
      cycle(($urandom_range(99, 0) < 40), t);
    end

    // Miss storm to saturate the counter.
    lat_min = 1;
    lat_max = 3;
    for (int i = 0; i < 70000; i++) cycle(1'b1, 5);
`ifdef OLED_PIXEL_FETCH_STATS_EN
    check("miss_sat", miss_cnt, 16'hFFFF);
`else
    check("miss_sat", miss_cnt, 0);
`endif

    // Drain.
    n = 0;
    while (pend_valid && (n < 20)) begin
      cycle(1'b0, 0);
      n++;
    end
    cycle(1'b0, 0);
    cycle(1'b0, 0);
    check("sb_drain", exp_colors.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
